median_window_sequencer: RTL and testbench

- Streaming controller that drives the combinational 3x3 median datapath.
- Buffers two image lines, builds a 3x3 window per pixel and presents it on a flat bus to the filter.
- Captures the returned median and emits a registered, raster-ordered output stream with frame and line markers.
- Border pixels bypass the filter. Sits between the camera pixel stream and the tracking logic.

---
 rtl/median_window_sequencer_pkg.sv | 20 ++
 rtl/median_line_buffer.sv | 33 +++
 rtl/median_window_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_median_window_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/median_window_sequencer_pkg.sv
// Shared types and constants for the 3x3 median window sequencer.
// State encoding, window geometry and a counter-width helper.
package median_window_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } seq_state_e;

  localparam int unsigned WIN_SIZE   = 9;
  localparam int unsigned WIN_CENTER = 4;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (n > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/median_line_buffer.sv
// Fixed-depth pixel delay line: on each enabled clock the oldest pixel is presented on data_o
// and the new pixel enters at the head.
module median_line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 640
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en_i) begin
      mem_d[0] = data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // Contents are don't-care after reset, so no reset is applied.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o = mem_q[DEPTH-1];

endmodule

// File: rtl/median_window_sequencer.sv
// Streaming 3x3 window builder around an external combinational median filter.
// Emits a raster-ordered output stream with frame/line markers; border pixels bypass the filter.
module median_window_sequencer
  import median_window_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic [DATA_WIDTH-1:0]          inData,
  input  logic                           inSof,
  output logic [DATA_WIDTH*WIN_SIZE-1:0] windowData,
  input  logic [DATA_WIDTH-1:0]          medianData,
  output logic                           outValid,
  output logic [DATA_WIDTH-1:0]          outData,
  output logic                           outSof,
  output logic                           outEol,
  output logic                           busy,
  output logic                           frameError
);

  if (IMG_WIDTH < 3) begin : g_bad_width
    $error("IMG_WIDTH must be >= 3");
  end
  if (IMG_HEIGHT < 3) begin : g_bad_height
    $error("IMG_HEIGHT must be >= 3");
  end

  localparam int unsigned XW = cnt_width(IMG_WIDTH);
  localparam int unsigned YW = cnt_width(IMG_HEIGHT);
  localparam int unsigned FW = cnt_width(IMG_WIDTH + 2);

  localparam logic [XW-1:0] XLast     = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YLast     = YW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FillFull  = FW'(IMG_WIDTH + 1);
  localparam logic [FW-1:0] FlushLast = FW'(IMG_WIDTH);

  seq_state_e            state_q, state_d;
  logic [XW-1:0]         in_x_q, in_x_d;
  logic [YW-1:0]         in_y_q, in_y_d;
  logic [XW-1:0]         out_x_q, out_x_d;
  logic [YW-1:0]         out_y_q, out_y_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic [DATA_WIDTH-1:0] win_q [WIN_SIZE];
  logic [DATA_WIDTH-1:0] win_d [WIN_SIZE];
  logic                  win_vld_q, win_vld_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_sof_q, out_sof_d;
  logic                  out_eol_q, out_eol_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  frame_err_q, frame_err_d;

  logic                  xfer, sof_xfer, shift, abort, emit, border;
  logic [DATA_WIDTH-1:0] shift_px, lb1_out, lb2_out;

  assign xfer     = inValid && in_ready_q;
  assign sof_xfer = xfer && inSof;

  // lb1 delays the incoming pixel by one line, lb2 by two lines.
  median_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_line_buf1 (
    .clk_i  (clk),
    .en_i   (shift),
    .data_i (shift_px),
    .data_o (lb1_out)
  );

  median_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_line_buf2 (
    .clk_i  (clk),
    .en_i   (shift),
    .data_i (lb1_out),
    .data_o (lb2_out)
  );

  for (genvar i = 0; i < WIN_SIZE; i++) begin : g_win_bus
    assign windowData[DATA_WIDTH*i +: DATA_WIDTH] = win_q[i];
  end

  always_comb begin
    state_d  = state_q;
    in_x_d   = in_x_q;
    in_y_d   = in_y_q;
    flush_d  = flush_q;
    shift    = 1'b0;
    shift_px = '0;
    abort    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sof_xfer) begin
          state_d  = StRun;
          shift    = 1'b1;
          shift_px = inData;
          in_x_d   = XW'(1);
          in_y_d   = '0;
        end
      end
      StRun: begin
        if (xfer) begin
          shift    = 1'b1;
          shift_px = inData;
          if (inSof) begin
            abort  = 1'b1;
            in_x_d = XW'(1);
            in_y_d = '0;
          end else if (in_x_q == XLast) begin
            in_x_d = '0;
            if (in_y_q == YLast) begin
              in_y_d  = '0;
              state_d = StFlush;
              flush_d = '0;
            end else begin
              in_y_d = in_y_q + YW'(1);
            end
          end else begin
            in_x_d = in_x_q + XW'(1);
          end
        end
      end
      StFlush: begin
        // Zero pixels push the last row's windows through.
        shift = 1'b1;
        if (flush_q == FlushLast) begin
          state_d = StIdle;
          flush_d = '0;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Window shift and completion tracking: a window is complete once the first
  // IMG_WIDTH+1 pixels of the frame have been shifted past its centre.
  always_comb begin
    win_d     = win_q;
    fill_d    = fill_q;
    win_vld_d = 1'b0;
    if (shift) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_out;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_out;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = shift_px;
      if (sof_xfer) begin
        fill_d = FW'(1);
      end else begin
        win_vld_d = (fill_q == FillFull);
        fill_d    = (fill_q == FillFull) ? fill_q : fill_q + FW'(1);
      end
    end
  end

  assign emit   = win_vld_q && !abort;
  assign border = (out_x_q == '0) || (out_x_q == XLast) || (out_y_q == '0) || (out_y_q == YLast);

  always_comb begin
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_valid_d = emit;
    out_data_d  = out_data_q;
    out_sof_d   = 1'b0;
    out_eol_d   = 1'b0;
    if (emit) begin
      out_data_d = border ? win_q[WIN_CENTER] : medianData;
      out_sof_d  = (out_x_q == '0) && (out_y_q == '0);
      out_eol_d  = (out_x_q == XLast);
      if (out_x_q == XLast) begin
        out_x_d = '0;
        out_y_d = (out_y_q == YLast) ? '0 : out_y_q + YW'(1);
      end else begin
        out_x_d = out_x_q + XW'(1);
      end
    end
    if (abort) begin
      out_x_d = '0;
      out_y_d = '0;
    end
    busy_d      = (state_d != StIdle);
    in_ready_d  = (state_d != StFlush);
    frame_err_d = abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_x_q      <= '0;
      in_y_q      <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      fill_q      <= '0;
      flush_q     <= '0;
      win_q       <= '{default: '0};
      win_vld_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_x_q      <= in_x_d;
      in_y_q      <= in_y_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      fill_q      <= fill_d;
      flush_q     <= flush_d;
      win_q       <= win_d;
      win_vld_q   <= win_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign inReady    = in_ready_q;
  assign outValid   = out_valid_q;
  assign outData    = out_data_q;
  assign outSof     = out_sof_q;
  assign outEol     = out_eol_q;
  assign busy       = busy_q;
  assign frameError = frame_err_q;

endmodule

// File: tb/tb_median_window_sequencer.sv
// Scoreboard bench for median_window_sequencer on a 4x4 image with a behavioural median filter
// and an image-level reference model.
module tb_median_window_sequencer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            inValid = 1'b0;
  logic            inSof = 1'b0;
  logic [DW-1:0]   inData = '0;
  logic            inReady, outValid, outSof, outEol, busy, frameError;
  logic [DW-1:0]   medianData, outData;
  logic [DW*9-1:0] windowData;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    int         x;
    int         y;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] img [H][W];
  logic [7:0] cap [H][W];
  int checks = 0, errors = 0, out_cnt = 0, ready_low = 0, ferr_cnt = 0;
  int base_out, base_rl, base_fe;

  median_window_sequencer #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inValid    (inValid),
    .inReady    (inReady),
    .inData     (inData),
    .inSof      (inSof),
    .windowData (windowData),
    .medianData (medianData),
    .outValid   (outValid),
    .outData    (outData),
    .outSof     (outSof),
    .outEol     (outEol),
    .busy       (busy),
    .frameError (frameError)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] med9(input logic [71:0] b);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = b[8*i +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  // Behavioural stand-in for the combinational filter.
  assign medianData = med9(windowData);

  function automatic logic [7:0] ref_px(input int x, input int y);
    logic [71:0] b;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return img[y][x];
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        b[8*(3*(dy+1)+(dx+1)) +: 8] = img[y+dy][x+dx];
    return med9(b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.data = ref_px(x, y);
        e.sof  = (x == 0 && y == 0);
        e.eol  = (x == W - 1);
        e.x    = x;
        e.y    = y;
        exp_q.push_back(e);
      end
  endtask

  task automatic send_px(input logic [7:0] d, input logic s);
    int n = 0;
    inValid = 1'b1;
    inData  = d;
    inSof   = s;
    while (!inReady && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_ready: inReady stuck at %0d, expected 1", inReady);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    inSof   = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle after each pixel, 2: random idle cycles.
  task automatic send_pixels(input int first, input int count, input int mode);
    int gap;
    for (int k = first; k < first + count; k++) begin
      send_px(img[k / W][k % W], k == 0);
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (gap) begin
        inData = 8'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(n >= 300), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string name, input int mode);
    base_out = out_cnt;
    push_expected();
    send_pixels(0, W * H, mode);
    wait_done(name);
    chk({name, "_out_count"}, out_cnt - base_out, W * H);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!inReady) ready_low++;
      if (frameError) ferr_cnt++;
      if (outValid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h, expected no output", outData);
        end else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("out_data(%0d,%0d)", mon_e.x, mon_e.y), 32'(outData), 32'(mon_e.data));
          chk($sformatf("out_sof(%0d,%0d)", mon_e.x, mon_e.y), 32'(outSof), 32'(mon_e.sof));
          chk($sformatf("out_eol(%0d,%0d)", mon_e.x, mon_e.y), 32'(outEol), 32'(mon_e.eol));
          cap[mon_e.y][mon_e.x] = outData;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 32'(outValid), 0);
    chk("rst_out_sof", 32'(outSof), 0);
    chk("rst_out_eol", 32'(outEol), 0);
    chk("rst_in_ready", 32'(inReady), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_error", 32'(frameError), 0);

    send_px(8'h33, 1'b0);
    chk("idle_drop_busy", 32'(busy), 0);

    // Constant frame.
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'h55;
    base_rl = ready_low;
    run_frame("const", 0);
    chk("const_flush_ready_low", ready_low - base_rl, W + 1);
    chk("const_busy_after", 32'(busy), 0);
    chk("const_out_11", 32'(cap[1][1]), 32'h55);

    // Ramp.
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'(16 * y + x);
    run_frame("ramp", 0);
    chk("ramp_out_11", 32'(cap[1][1]), 32'h11);
    chk("ramp_out_22", 32'(cap[2][2]), 32'h22);
    chk("ramp_out_30", 32'(cap[0][3]), 32'h03);

    // Impulse is removed by the filter.
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'h10;
    img[1][1] = 8'hFF;
    run_frame("impulse", 0);
    chk("impulse_out_11", 32'(cap[1][1]), 32'h10);
    chk("impulse_out_21", 32'(cap[1][2]), 32'h10);

    // Ramp with alternating gaps.
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'(16 * y + x);
    run_frame("ramp_gaps", 1);
    chk("ramp_gaps_out_12", 32'(cap[2][1]), 32'h21);

    // Random images with random gaps.
    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'($urandom);
      run_frame($sformatf("random%0d", f), 2);
    end

    // Abort: six pixels of an old frame, then inSof on the seventh.
    base_fe = ferr_cnt;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'h77;
    for (int k = 0; k < 6; k++) send_px(8'h77, k == 0);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'h20;
    run_frame("abort", 0);
    chk("abort_frame_error_pulses", ferr_cnt - base_fe, 1);
    chk("abort_busy_after", 32'(busy), 0);

    // Reset in the middle of a frame.
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'($urandom);
    push_expected();
    send_pixels(0, 9, 0);
    chk("mid_out_valid_before_reset", 32'(outValid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 32'(outValid), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    chk("mid_reset_in_ready", 32'(inReady), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'($urandom);
    run_frame("after_reset", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
